// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, main memory and mem_arbiter.
// The arbiter takes the slave side; caches and memory together take the master side.
interface mem_arbiter_if #(
  parameter int bit_size = 32,
  parameter int WORDS    = 4
);
  localparam int CW = $clog2(WORDS);

  logic                ic_req;
  logic [bit_size-1:0] ic_addr;
  logic [bit_size-1:0] ic_rdata;
  logic                ic_rvalid;
  logic                ic_done;

  logic                dc_req;
  logic                dc_we;
  logic [bit_size-1:0] dc_addr;
  logic [bit_size-1:0] dc_wdata;
  logic                dc_wnext;
  logic [bit_size-1:0] dc_rdata;
  logic                dc_rvalid;
  logic                dc_done;

  logic [CW-1:0]       word_idx;

  // Handshake: a memory beat transfers in every cycle where mem_req and mem_ready
  // are both high; mem_req, mem_we, mem_addr and mem_wdata hold until that cycle.
  // Cache requests are level-held until the matching one-cycle done pulse.
  logic                mem_req;
  logic                mem_we;
  logic [bit_size-1:0] mem_addr;
  logic [bit_size-1:0] mem_wdata;
  logic [bit_size-1:0] mem_rdata;
  logic                mem_ready;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    output ic_rdata, ic_rvalid, ic_done, dc_wnext, dc_rdata, dc_rvalid, dc_done,
           word_idx, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    input  ic_rdata, ic_rvalid, ic_done, dc_wnext, dc_rdata, dc_rvalid, dc_done,
           word_idx, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refill/write-back bursts.
// Define ARB_RR_EN to alternate grants on ties; otherwise the D-cache always wins a tie.
module mem_arbiter #(
  parameter int bit_size = 32,
  parameter int WORDS    = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic [2:0]        dbg_state_o
);
  localparam int CW  = $clog2(WORDS);
  localparam int LSB = CW + 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IC_RD = 3'd1,
    S_DC_RD = 3'd2,
    S_DC_WR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  state_t              state_q;
  owner_t              owner_q;
  logic [bit_size-1:0] base_q;
  logic [bit_size-1:0] addr_q;
  logic [CW-1:0]       cnt_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic                ic_done_q;
  logic                dc_done_q;
`ifdef ARB_RR_EN
  owner_t              last_grant_q;
`endif

  logic [bit_size-1:0] ic_base;
  logic [bit_size-1:0] dc_base;
  logic [bit_size-1:0] next_addr;
  logic [CW-1:0]       cnt_inc;
  logic                grant_dc;
  logic                last_beat;
  logic                in_burst;
  logic                unused_addr_lsbs;

  assign ic_base   = {bus.ic_addr[bit_size-1:LSB], {LSB{1'b0}}};
  assign dc_base   = {bus.dc_addr[bit_size-1:LSB], {LSB{1'b0}}};
  assign cnt_inc   = cnt_q + CW'(1);
  assign next_addr = base_q + {{(bit_size-LSB){1'b0}}, cnt_inc, 2'b00};
  assign last_beat = (cnt_q == CW'(WORDS-1));
  assign in_burst  = (state_q == S_IC_RD) || (state_q == S_DC_RD) || (state_q == S_DC_WR);

  // Offset bits within a block never reach the memory address.
  assign unused_addr_lsbs = ^{bus.ic_addr[LSB-1:0], bus.dc_addr[LSB-1:0]};

  always_comb begin
    grant_dc = bus.dc_req;
`ifdef ARB_RR_EN
    if (bus.dc_req && bus.ic_req) grant_dc = (last_grant_q == OWN_IC);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IC;
      base_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_q <= OWN_IC;
`endif
    end else begin
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.dc_req || bus.ic_req) begin
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            if (grant_dc) begin
              owner_q  <= OWN_DC;
              base_q   <= dc_base;
              addr_q   <= dc_base;
              mem_we_q <= bus.dc_we;
              state_q  <= bus.dc_we ? S_DC_WR : S_DC_RD;
            end else begin
              owner_q  <= OWN_IC;
              base_q   <= ic_base;
              addr_q   <= ic_base;
              mem_we_q <= 1'b0;
              state_q  <= S_IC_RD;
            end
`ifdef ARB_RR_EN
            last_grant_q <= grant_dc ? OWN_DC : OWN_IC;
`endif
          end
        end
        S_IC_RD, S_DC_RD, S_DC_WR: begin
          // Without mem_ready every registered output simply holds.
          if (bus.mem_ready) begin
            cnt_q <= cnt_inc;
            if (last_beat) begin
              state_q   <= S_DONE;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              addr_q    <= '0;
              ic_done_q <= (owner_q == OWN_IC);
              dc_done_q <= (owner_q == OWN_DC);
            end else begin
              addr_q <= next_addr;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_we_q ? bus.dc_wdata : '0;
  assign bus.word_idx  = cnt_q;

  assign bus.ic_rdata  = bus.mem_rdata;
  assign bus.dc_rdata  = bus.mem_rdata;
  assign bus.ic_rvalid = in_burst && (state_q == S_IC_RD) && bus.mem_ready;
  assign bus.dc_rvalid = in_burst && (state_q == S_DC_RD) && bus.mem_ready;
  assign bus.dc_wnext  = in_burst && (state_q == S_DC_WR) && bus.mem_ready;
  assign bus.ic_done   = ic_done_q;
  assign bus.dc_done   = dc_done_q;

  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a burst-level model.
// Build with ARB_RR_EN defined to exercise the alternating-grant variant.
module tb_mem_arbiter;
  localparam int BW    = 32;
  localparam int WORDS = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state_unused;

  mem_arbiter_if #(.bit_size(BW), .WORDS(WORDS)) bus();

  mem_arbiter #(.bit_size(BW), .WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state_unused)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: one burst = grant, WORDS beats, done
  int            m_phase = 0;   // 0 no burst, 1 beats in flight, 2 completion cycle
  bit            m_dc = 1'b0;
  bit            m_we = 1'b0;
  bit            m_last_dc = 1'b0;
  logic [BW-1:0] m_base = '0;
  int            m_beat = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];
  bit            grant_q[$];

  int  n_vec = 0;
  int  n_err = 0;
  bit  auto_drop = 1'b1;
  int  ready_mode = 0;
  bit  ready_t = 1'b0;
  bit  ic_done_seen = 1'b0;
  bit  dc_done_seen = 1'b0;
  int  ic_done_cnt = 0;
  int  dc_done_cnt = 0;
  int  req_cycles = 0;
  int  we_cycles = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit gdc;
    if (rst) begin
      m_phase = 0; m_beat = 0; m_base = '0; m_last_dc = 1'b0; m_dc = 1'b0; m_we = 1'b0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (bus.ic_req || bus.dc_req) begin
          gdc = bus.dc_req && !(bus.ic_req && RR && m_last_dc);
          m_dc = gdc;
          m_we = gdc && bus.dc_we;
          m_base = (gdc ? bus.dc_addr : bus.ic_addr) & ~BW'(WORDS*4-1);
          m_beat = 0;
          m_phase = 1;
          m_last_dc = gdc;
          for (int i = 0; i < WORDS; i++) exp_q.push_back(m_base + BW'(4*i));
        end
        1: if (bus.mem_ready) begin
          m_beat++;
          if (m_beat == WORDS) begin m_phase = 2; m_beat = 0; end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic monitor();
    bit         act;
    logic [6:0] ectl, gctl;
    act  = (m_phase == 1);
    ectl = {act, act && m_we, act && !m_dc && bus.mem_ready, act && m_dc && !m_we && bus.mem_ready,
            act && m_we && bus.mem_ready, (m_phase == 2) && !m_dc, (m_phase == 2) && m_dc};
    gctl = {bus.mem_req, bus.mem_we, bus.ic_rvalid, bus.dc_rvalid, bus.dc_wnext, bus.ic_done, bus.dc_done};
    check("ctl", 64'(gctl), 64'(ectl));
    check("addr", 64'(bus.mem_addr), act ? 64'(m_base + BW'(4*m_beat)) : 64'd0);
    check("widx", 64'(bus.word_idx), act ? 64'(m_beat) : 64'd0);
    check("wdata", 64'(bus.mem_wdata), (act && m_we) ? 64'(bus.dc_wdata) : 64'd0);
    if (ectl[4]) check("ic_rdata", 64'(bus.ic_rdata), 64'(bus.mem_rdata));
    if (ectl[3]) check("dc_rdata", 64'(bus.dc_rdata), 64'(bus.mem_rdata));
    if (bus.mem_req && bus.mem_ready) begin
      obs_q.push_back(bus.mem_addr);
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("sb_addr", 64'(bus.mem_addr), 64'(exp_q.pop_front()));
    end
    if (bus.mem_req) req_cycles++;
    if (bus.mem_req && bus.mem_we) we_cycles++;
    if (bus.ic_done) begin ic_done_seen = 1'b1; ic_done_cnt++; grant_q.push_back(1'b0); end
    if (bus.dc_done) begin dc_done_seen = 1'b1; dc_done_cnt++; grant_q.push_back(1'b1); end
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); monitor(); end

  // ---------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drop && ic_done_seen) bus.ic_req = 1'b0;
    if (auto_drop && dc_done_seen) bus.dc_req = 1'b0;
    ic_done_seen = 1'b0;
    dc_done_seen = 1'b0;
    case (ready_mode)
      0:       bus.mem_ready = 1'b1;
      1:       begin ready_t = !ready_t; bus.mem_ready = ready_t; end
      default: bus.mem_ready = 1'($urandom_range(0, 1));
    endcase
    bus.mem_rdata = $urandom;
    bus.dc_wdata  = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
    ready_mode = 0;
    auto_drop = 1'b1;
    step();
    step();
    rst = 1'b0;
    obs_q.delete();
    grant_q.delete();
    ic_done_cnt = 0; dc_done_cnt = 0; req_cycles = 0; we_cycles = 0;
  endtask

  // ---------------- scenarios
  initial begin
    logic [BW-1:0] base;
    int            done_snap;
    bus.ic_req = 1'b0; bus.ic_addr = '0; bus.dc_req = 1'b0; bus.dc_we = 1'b0;
    bus.dc_addr = '0; bus.dc_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;

    // IC refill, memory always ready
    do_reset();
    bus.ic_addr = 32'h104; bus.ic_req = 1'b1;
    repeat (WORDS + 4) step();
    base = 32'h104 & ~BW'(WORDS*4-1);
    check("t1_nbeats", 64'(obs_q.size()), 64'(WORDS));
    for (int i = 0; i < obs_q.size(); i++) check("t1_beat_addr", 64'(obs_q[i]), 64'(base + BW'(4*i)));
    check("t1_ic_done", 64'(ic_done_cnt), 64'd1);
    check("t1_req_cycles", 64'(req_cycles), 64'(WORDS));

    // simultaneous requests: DC refill first, then IC
    do_reset();
    bus.ic_addr = 32'h040; bus.dc_addr = 32'h388; bus.dc_we = 1'b0;
    bus.ic_req = 1'b1; bus.dc_req = 1'b1;
    repeat (2*WORDS + 8) step();
    check("t2_ngrants", 64'(grant_q.size()), 64'd2);
    if (grant_q.size() >= 2) begin
      check("t2_first_dc", 64'(grant_q[0]), 64'd1);
      check("t2_second_ic", 64'(grant_q[1]), 64'd0);
    end

    // DC write-back with mem_ready toggling, first burst cycle not ready
    do_reset();
    ready_mode = 1; ready_t = 1'b0;
    step();
    bus.dc_addr = 32'h200; bus.dc_we = 1'b1; bus.dc_req = 1'b1;
    repeat (2*WORDS + 4) step();
    check("t3_req_cycles", 64'(req_cycles), 64'(2*WORDS));
    check("t3_we_cycles", 64'(we_cycles), 64'(2*WORDS));
    check("t3_dc_done", 64'(dc_done_cnt), 64'd1);
    check("t3_nbeats", 64'(obs_q.size()), 64'(WORDS));
    for (int i = 0; i < obs_q.size(); i++) check("t3_beat_addr", 64'(obs_q[i]), 64'(32'h200 + 4*i));

    // reset after two IC beats, then re-request
    do_reset();
    bus.ic_addr = 32'h10C; bus.ic_req = 1'b1;
    step(); step(); step();
    rst = 1'b1; bus.mem_ready = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t4_mem_req", 64'(bus.mem_req), 64'd0);
    check("t4_word_idx", 64'(bus.word_idx), 64'd0);
    check("t4_mem_addr", 64'(bus.mem_addr), 64'd0);
    done_snap = ic_done_cnt;
    check("t4_no_done", 64'(done_snap), 64'd0);
    repeat (WORDS + 4) step();
    check("t4_ic_done", 64'(ic_done_cnt), 64'd1);
    check("t4_nbeats", 64'(obs_q.size()), 64'(WORDS + 2));
    if (obs_q.size() > 2) check("t4_restart_addr", 64'(obs_q[2]), 64'h100);

    // both requests held: grant order depends on ARB_RR_EN
    do_reset();
    auto_drop = 1'b0;
    bus.ic_addr = 32'h500; bus.dc_addr = 32'h600; bus.dc_we = 1'b0;
    bus.ic_req = 1'b1; bus.dc_req = 1'b1;
    repeat (4*(WORDS + 2)) step();
    check("t5_ngrants", 64'(grant_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check("t5_grant_owner", 64'(grant_q[i]), RR ? 64'((i % 2) == 0) : 64'd1);
    bus.ic_req = 1'b0; bus.dc_req = 1'b0;
    repeat (WORDS + 3) step();

    // dc_req dropped mid-burst: burst still completes
    do_reset();
    bus.dc_addr = 32'h7F0; bus.dc_we = 1'b0; bus.dc_req = 1'b1;
    step(); step(); step();
    bus.dc_req = 1'b0;
    repeat (WORDS + 3) step();
    check("t6_dc_done", 64'(dc_done_cnt), 64'd1);
    check("t6_nbeats", 64'(obs_q.size()), 64'(WORDS));

    // random traffic, random ready, occasional reset
    do_reset();
    ready_mode = 2;
    for (int c = 0; c < 600; c++) begin
      step();
      rst = ($urandom_range(0, 149) == 0);
      if (!bus.ic_req && $urandom_range(0, 3) == 0) begin
        bus.ic_req = 1'b1; bus.ic_addr = $urandom;
      end
      if (!bus.dc_req && $urandom_range(0, 3) == 0) begin
        bus.dc_req = 1'b1; bus.dc_addr = $urandom; bus.dc_we = 1'($urandom_range(0, 1));
      end
    end
    rst = 1'b0;
    bus.ic_req = 1'b0; bus.dc_req = 1'b0;
    ready_mode = 0;
    repeat (WORDS + 4) step();
    check("end_idle", 64'(bus.mem_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache refill path and the D-cache refill/write-back path.
- Accepts one block-transfer request at a time and sequences it as a burst of WORDS single-word memory beats.
- Returns each beat to the granted cache and pulses that cache's done flag at the end.
- Sits between the two cache controllers and main memory; the caches hold IC_stall/DC_stall until their done pulse.

Parameters:
- bit_size, 32: data/address width.
- WORDS, 4: words per cache block; power of two, at least 2.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ic_req  input  1  I-cache refill request; held until ic_done
ic_addr  input  bit_size  I-cache miss address; low log2(WORDS)+2 bits ignored
ic_rdata  output  bit_size  refill word, equals mem_rdata
ic_rvalid  output  1  ic_rdata valid this cycle
ic_done  output  1  one-cycle pulse, I-cache block complete
dc_req  input  1  D-cache request; held until dc_done
dc_we  input  1  1 = write-back burst, 0 = refill burst; sampled at grant
dc_addr  input  bit_size  D-cache block address; low bits ignored
dc_wdata  input  bit_size  current write-back word
dc_wnext  output  1  dc_wdata consumed this cycle; D-cache advances its word pointer
dc_rdata  output  bit_size  refill word, equals mem_rdata
dc_rvalid  output  1  dc_rdata valid this cycle
dc_done  output  1  one-cycle pulse, D-cache burst complete
word_idx  output  log2(WORDS)  index of the current beat
mem_req  output  1  memory access request
mem_we  output  1  memory write enable
mem_addr  output  bit_size  word address, base + word_idx*4
mem_wdata  output  bit_size  equals dc_wdata during a write burst, else 0
mem_rdata  input  bit_size  memory read data
mem_ready  input  1  beat completes this cycle

Behaviour:
- States:
  - IDLE: no burst active.
  - IC_RD: I-cache refill burst.
  - DC_RD: D-cache refill burst.
  - DC_WR: D-cache write-back burst.
  - DONE: one-cycle completion state.
- Registered state: state, owner (IC/DC), base (block-aligned address), cnt (log2(WORDS) bits), last_grant.
- Reset values:
  - state=IDLE, cnt=0, base=0, last_grant=IC.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, rvalid, done, wnext, word_idx.
- IDLE:
  - If a request is present, latch the winner's address with the low bits cleared, clear cnt, and go to the burst state next cycle. dc_we selects DC_WR or DC_RD.
  - If both requests are present, DC wins (fixed priority).
  - First mem_req comes 1 cycle after the req edge is sampled.
- Burst states:
  - mem_req=1; mem_we=1 only in DC_WR; mem_addr = base + {cnt,2'b00}; word_idx=cnt.
  - On mem_ready:
    - Read bursts: rvalid=1 for the owner, rdata=mem_rdata (combinational).
    - Write bursts: dc_wnext=1.
    - cnt increments.
  - No mem_ready: cnt, address and all control outputs hold; the wait length is unbounded.
  - mem_ready together with cnt==WORDS-1: go to DONE; cnt wraps to 0.
- DONE:
  - The owner's done=1 for exactly this cycle; mem_req=0.
  - Requests are ignored; the next state is IDLE.
  - The owner must drop req by the following IDLE cycle.
- A req that drops mid-burst is ignored; the burst completes.
- A new request arriving mid-burst waits; it is granted at the earliest 1 cycle after DONE.
- mem_ready outside burst states is ignored.
- rst mid-burst: next cycle is IDLE with all outputs 0 and partial data discarded. The caches re-request.
- Minimum burst is WORDS+2 cycles from req sample to done: 1 grant cycle, WORDS beats, 1 DONE cycle.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - On a tie in IDLE, grant the requester not equal to last_grant.
  - last_grant updates at every grant; it resets to IC, so the first tie goes to DC.
- Undefined:
  - Fixed DC-over-IC priority on ties.
  - The last_grant register is not built.

Test Plan:
- IC only, ic_addr=0x104, mem_ready=1 constantly:
  - mem_addr = 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles.
  - ic_rvalid high for those 4 cycles; ic_done pulses in the next cycle; mem_req=0 in the DONE cycle.
- ic_req and dc_req (dc_we=0) rise together:
  - DC refill is served first, dc_done pulses.
  - One IDLE cycle follows, then the IC burst starts; ic_rvalid never high during the DC burst.
- DC write-back, dc_addr=0x200, mem_ready toggling 1/0:
  - mem_we=1 throughout.
  - dc_wnext only on ready cycles; mem_addr steps only after a ready.
  - Total 8 beat cycles, then dc_done.
- rst asserted after 2 IC beats:
  - Next cycle: state IDLE, mem_req=0, word_idx=0, ic_done never pulses.
  - A re-request restarts at 0x100.
- ARB_RR_EN defined, both requests held continuously: grant order DC, IC, DC, IC.
- ARB_RR_EN undefined, same stimulus: DC is granted every time.
- dc_req dropped mid-burst: the burst still completes all WORDS beats and dc_done pulses.
